// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled BCD up/down counter with per-digit seven-segment outputs; define BCD_TICK_COUNTER_SATURATE_EN to saturate instead of wrap.
module bcd_tick_counter #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [8*DIGITS-1:0]   seg_out,
  output logic                  tick_out,
  output logic                  wrap
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic tick, all9, all0, at_edge;
  logic [4*DIGITS-1:0] inc, dec, ld, nxt;
  assign tick = en && pre == PW'(TICK_DIV - 1);
  always_comb begin
    inc  = count_bcd;
    dec  = count_bcd;
    ld   = load_val;
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ld[4*i+:4]  = load_val[4*i+:4] > 4'd9 ? 4'd9 : load_val[4*i+:4];
      inc[4*i+:4] = all9 ? (count_bcd[4*i+:4] == 4'd9 ? 4'd0 : count_bcd[4*i+:4] + 4'd1) : count_bcd[4*i+:4];
      dec[4*i+:4] = all0 ? (count_bcd[4*i+:4] == 4'd0 ? 4'd9 : count_bcd[4*i+:4] - 4'd1) : count_bcd[4*i+:4];
      all9 = all9 && count_bcd[4*i+:4] == 4'd9;
      all0 = all0 && count_bcd[4*i+:4] == 4'd0;
    end
  end
  assign at_edge = up_dn ? all9 : all0;
`ifdef BCD_TICK_COUNTER_SATURATE_EN
  assign nxt = at_edge ? count_bcd : (up_dn ? inc : dec);
`else
  assign nxt = up_dn ? inc : dec;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_bcd <= '0;
      pre       <= '0;
      tick_out  <= 1'b0;
      wrap      <= 1'b0;
    end else if (clr || load) begin
      count_bcd <= clr ? '0 : ld;
      pre       <= '0;
      tick_out  <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      pre       <= tick ? '0 : (en ? pre + PW'(1) : pre);
      tick_out  <= tick;
      wrap      <= tick && at_edge;
      count_bcd <= tick ? nxt : count_bcd;
    end
  end
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg_out[8*g+:8] = seg7(count_bcd[4*g+:4]);
  end
endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
Parametrised successor to the fixed-width free-running inc/dec counters and the two-digit seven-segment path.
- Divides the system clock into a count tick with an internal prescaler.
- Keeps a DIGITS-wide decimal (BCD) up/down counter with synchronous clear, parallel load and wrap pulse.
- Drives one seven-segment pattern per digit directly, removing the binary-to-decimal %/÷ logic in top.

Parameters:
DIGITS, 2, number of BCD digits (1..8)
TICK_DIV, 50000000, clk cycles per count tick while en=1 (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  1 = prescaler runs; 0 = prescaler and count hold
up_dn  in  1  1 = count up, 0 = count down
clr  in  1  synchronous clear of count and prescaler
load  in  1  synchronous parallel load
load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0]
count_bcd  out  4*DIGITS  current count, BCD, digit 0 least significant
seg_out  out  8*DIGITS  seven-seg pattern per digit, digit 0 in [7:0]
tick_out  out  1  one-cycle pulse on every count tick
wrap  out  1  one-cycle pulse when count wraps (or saturates, see option)

Behaviour:
- Reset (async, rst=1):
  - count_bcd=0, prescaler=0, tick_out=0, wrap=0.
  - Every seg_out byte = 8'hC0.
  - Outputs are held for as long as rst=1.
- Prescaler:
  - Width $clog2(TICK_DIV), minimum 1.
  - Increments each clk while en=1.
  - At value TICK_DIV-1 it returns to 0 and asserts the internal tick for that cycle.
  - TICK_DIV=1: tick on every cycle with en=1.
  - en=0: prescaler holds its value; no ticks occur.
- tick_out: registered copy of the internal tick. Goes high the cycle after the prescaler wraps; exactly 1 cycle wide.
- Count update on the same edge that registers tick_out. Priority: clr > load > tick.
  - clr=1: count=0, prescaler=0, no tick, no wrap. Ignores en.
  - load=1: count=load_val, prescaler=0, no wrap. Any load digit >9 is stored as 9. Ignores en.
  - tick with up_dn=1: BCD increment. A digit at 9 becomes 0 and carries into the next digit.
  - tick with up_dn=0: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit.
- Wrap:
  - Up from all-9s gives 0; down from 0 gives all-9s.
  - wrap is asserted for 1 cycle, coincident with the register update, i.e. in the same cycle as tick_out.
- up_dn is sampled only at the tick; changing it between ticks has no other effect.
- Active-low encoding, bit order {dp,g,f,e,d,c,b,a}, dp always 1.
  - Digit codes: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90.
  - seg_out is decoded combinationally from the count register, so it changes in the same cycle as count_bcd.
- Every stored digit is always in 0..9; no invalid BCD value is reachable.

Optional Feature:
- Macro: BCD_TICK_COUNTER_SATURATE_EN.
- Defined:
  - Up at all-9s holds all-9s; down at 0 holds 0.
  - wrap pulses on each tick that is blocked this way, as a saturation indicator.
- Undefined: wrap-around behaviour as described above.

Test Plan:
- DIGITS=2, TICK_DIV=4. Pulse rst mid-run with en=1 → count_bcd, tick_out and wrap are 0 and seg_out=16'hC0C0 immediately, without waiting for a clk edge; the first tick_out comes 4 cycles after rst falls.
- en=1, up_dn=1, 40 cycles from 0 → 10 tick_out pulses, spaced 4 cycles; count_bcd=8'h10; seg_out=16'hF9C0.
- load load_val=8'h99, then up one tick → count_bcd=8'h00, wrap=1 coincident with tick_out. With SATURATE_EN: count_bcd stays 8'h99 and wrap=1.
- From 8'h00, up_dn=0, one tick → 8'h99, wrap=1. Then one more tick → 8'h98, wrap=0.
- Priority and hold checks:
  - clr and load asserted together in a tick cycle, load_val=8'h55 → count_bcd=0, tick_out=0.
  - load_val=8'hAF → count_bcd=8'h99.
  - en=0 for 10 cycles → count and prescaler unchanged.
- DIGITS=4, TICK_DIV=1, from 16'h0999, one up tick → 16'h1000: carry ripples through three digits in one cycle.
